// File: rtl/system_0_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares
// them against expected constants, with per-read timeout and bounded retry.
module system_0_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h649C_4239,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]      RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic            AUTO_INIT   = (AUTO_START != 0);

    logic [2:0]        state_q, state_d;
    logic              auto_q, auto_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]        retry_q, retry_d;
    logic              gap_q, gap_d;
    logic              pass_q, pass_d;
    logic              id_mm_q, id_mm_d;
    logic              ts_mm_q, ts_mm_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       cap_id_q, cap_id_d;
    logic [31:0]       cap_ts_q, cap_ts_d;

    logic in_read;

    assign in_read     = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    // gap_q holds avm_read low for the single idle cycle between retry attempts
    assign avm_read    = in_read && !gap_q;
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        auto_d     = 1'b0;
        wait_cnt_d = wait_cnt_q;
        retry_d    = retry_q;
        gap_d      = gap_q;
        pass_d     = pass_q;
        id_mm_d    = id_mm_q;
        ts_mm_d    = ts_mm_q;
        timeout_d  = timeout_q;
        cap_id_d   = cap_id_q;
        cap_ts_d   = cap_ts_q;

        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    state_d    = S_RD_ID;
                    pass_d     = 1'b0;
                    id_mm_d    = 1'b0;
                    ts_mm_d    = 1'b0;
                    timeout_d  = 1'b0;
                    retry_d    = '0;
                    wait_cnt_d = '0;
                    gap_d      = 1'b0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (!avm_waitrequest) begin
                    // Completion wins even on the cycle the stall limit is reached.
                    wait_cnt_d = '0;
                    retry_d    = '0;
                    if (state_q == S_RD_ID) begin
                        cap_id_d = avm_readdata;
                        state_d  = S_RD_TS;
                    end else begin
                        cap_ts_d = avm_readdata;
                        state_d  = S_CHECK;
                    end
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d    = retry_q + 4'd1;
                        wait_cnt_d = '0;
                        gap_d      = 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = S_FIN;
                    end
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                id_mm_d = (cap_id_q != EXPECTED_ID);
                ts_mm_d = (cap_ts_q != EXPECTED_TS);
                pass_d  = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS);
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            auto_q     <= AUTO_INIT;
            wait_cnt_q <= '0;
            retry_q    <= '0;
            gap_q      <= 1'b0;
            pass_q     <= 1'b0;
            id_mm_q    <= 1'b0;
            ts_mm_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cap_id_q   <= '0;
            cap_ts_q   <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            wait_cnt_q <= wait_cnt_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
            pass_q     <= pass_d;
            id_mm_q    <= id_mm_d;
            ts_mm_q    <= ts_mm_d;
            timeout_q  <= timeout_d;
            cap_id_q   <= cap_id_d;
            cap_ts_q   <= cap_ts_d;
        end
    end

endmodule
